// File: rtl/buzzer_pkg.sv
// Shared constants and state encoding for the buzzer arbiter and its tone divider.
package buzzer_pkg;

  localparam int PW_DEF = 17;
  localparam int RW_DEF = 11;

  // Note periods in clk cycles; M0 doubles as the default rest timing period.
  localparam int M0 = 98800;
  localparam int M1 = 95600;
  localparam int M2 = 85150;
  localparam int M3 = 75850;
  localparam int M4 = 71600;
  localparam int M5 = 63750;
  localparam int M6 = 56800;
  localparam int M7 = 50600;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator for one note: period counter, repeat counter and registered buzzer level.
module tone_divider
  import buzzer_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [PW-1:0] per,
  input  logic [RW-1:0] rep,
  input  logic          rest,
  output logic          last,
  output logic          buzzer
);

  logic [PW-1:0] cnt0;
  logic [RW-1:0] cnt1;
  logic          wrap;

  assign wrap = (cnt0 == per - PW'(1));
  assign last = run && wrap && (cnt1 == rep - RW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0   <= '0;
      cnt1   <= '0;
      buzzer <= 1'b1;
    end else if (!run) begin
      cnt0   <= '0;
      cnt1   <= '0;
      buzzer <= 1'b1;
    end else begin
      // High for the first half of each period; odd periods spend the extra cycle low.
      buzzer <= rest || (cnt0 < (per >> 1));
      if (wrap) begin
        cnt0 <= '0;
        cnt1 <= last ? '0 : cnt1 + RW'(1);
      end else begin
        cnt0 <= cnt0 + PW'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, non-preemptive owner of the buzzer pin: grant, play one note, silent gap, done.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int PW       = PW_DEF,
  parameter int RW       = RW_DEF,
  parameter int REST_PER = M0,
  parameter int GAP_CYC  = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*PW-1:0]   period,
  input  logic [NREQ*RW-1:0]   repeat_n,
  input  logic                 abort,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic                 buzzer
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  state_t        state, state_d;
  logic [OW-1:0] grant_idx;
  logic          grant_any, do_grant, do_done;
  logic          note_last, gap_last, run;
  logic [PW-1:0] sel_period, per_q;
  logic [RW-1:0] sel_rep, rep_q;
  logic          rest_q;
  logic [GW-1:0] gcnt;

  // Lowest set index wins: scan downwards so the last hit is the highest priority.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_any = 1'b1;
        grant_idx = OW'(i);
      end
    end
  end

  assign sel_period = period[int'(grant_idx)*PW +: PW];
  assign sel_rep    = repeat_n[int'(grant_idx)*RW +: RW];
  assign gap_last   = (gcnt == GAP_LAST);
  assign run        = (state == ST_PLAY) && !abort;
  assign busy       = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    do_grant = 1'b0;
    do_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any && !abort) begin
          do_grant = 1'b1;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (abort || (note_last && GAP_CYC == 0)) begin
          do_done = 1'b1;
          state_d = ST_IDLE;
        end else if (note_last) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort || gap_last) begin
          do_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack    <= '0;
      done   <= '0;
      owner  <= '0;
      per_q  <= '0;
      rep_q  <= '0;
      rest_q <= 1'b0;
      gcnt   <= '0;
    end else begin
      ack  <= do_grant ? (ONE << grant_idx) : '0;
      done <= do_done  ? (ONE << owner)     : '0;
      if (do_grant) begin
        owner  <= grant_idx;
        rest_q <= (sel_period < PW'(2));
        per_q  <= (sel_period < PW'(2)) ? PW'(REST_PER) : sel_period;
        rep_q  <= (sel_rep == '0) ? RW'(1) : sel_rep;
      end
      if (state == ST_GAP && !abort && !gap_last) gcnt <= gcnt + GW'(1);
      else                                        gcnt <= '0;
    end
  end

  tone_divider #(
    .PW (PW),
    .RW (RW)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .per    (per_q),
    .rep    (rep_q),
    .rest   (rest_q),
    .last   (note_last),
    .buzzer (buzzer)
  );

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench: stimulus pushes expected note transactions, a monitor replays them per cycle.
module tb_buzzer_arbiter;

  localparam int NREQ = 3;
  localparam int PW   = 8;
  localparam int RW   = 4;
  localparam int REST = 6;
  localparam int GAP  = 4;

  typedef struct {
    int idx;
    int per;
    int rep;
    bit rest;
    int done_at;  // sample index (after ack) where done is expected
  } exp_t;

  logic                 clk, rst_n, abort, busy, buzzer;
  logic [NREQ-1:0]      req, ack, done;
  logic [NREQ*PW-1:0]   period;
  logic [NREQ*RW-1:0]   repeat_n;
  logic [1:0]           owner;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   ack_count = 0, done_count = 0;
  int   tp[NREQ], tr[NREQ], ta[NREQ];

  buzzer_arbiter #(
    .NREQ(NREQ), .PW(PW), .RW(RW), .REST_PER(REST), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .period(period), .repeat_n(repeat_n),
    .abort(abort), .ack(ack), .done(done), .busy(busy), .owner(owner), .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int idx, input int p, input int r, input int abort_m);
    exp_t e;
    e.idx     = idx;
    e.rest    = (p < 2);
    e.per     = e.rest ? REST : p;
    e.rep     = (r == 0) ? 1 : r;
    e.done_at = (abort_m >= 0) ? abort_m + 1 : e.per * e.rep + GAP;
    return e;
  endfunction

  function automatic int exp_level(input exp_t e, input int k);
    if (e.rest) return 1;
    return ((k % e.per) < (e.per / 2)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (|ack)  ack_count++;
      if (|done) done_count++;
    end
  end

  // Monitor: each ack opens a transaction that is replayed sample by sample against the model.
  initial begin
    exp_t e;
    int   bad;
    bit   reset_hit;
    int   exp_b;
    forever begin
      @(negedge clk);
      if (rst_n && ack != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", int'(ack), 0);
        end else begin
          e = sb.pop_front();
          check("ack_onehot", int'(ack), 1 << e.idx);
          check("owner", int'(owner), e.idx);
          bad       = 0;
          reset_hit = 1'b0;
          for (int k = 1; k <= e.done_at && !reset_hit; k++) begin
            @(negedge clk);
            if (!rst_n) begin
              reset_hit = 1'b1;
            end else if (k < e.done_at) begin
              exp_b = (k <= e.per * e.rep) ? exp_level(e, k - 1) : 1;
              if (int'(buzzer) != exp_b || done != '0 || busy != 1'b1 || ack != '0) begin
                if (bad == 0)
                  $display("  deviation req %0d sample %0d: buzzer=%b want %0d done=%b busy=%b ack=%b",
                           e.idx, k, buzzer, exp_b, done, busy, ack);
                bad++;
              end
            end
          end
          if (!reset_hit) begin
            check("note_wave", bad, 0);
            check("done_onehot", int'(done), 1 << e.idx);
            check("busy_at_done", int'(busy), 0);
            check("buzzer_at_done", int'(buzzer), 1);
          end
        end
      end
    end
  end

  task automatic wait_ack(output int j);
    j = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) j = i;
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000; n++) begin
      if (done != '0) return;
      @(negedge clk);
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic load(input int i);
    period[i*PW +: PW]   = PW'(tp[i]);
    repeat_n[i*RW +: RW] = RW'(tr[i]);
  endtask

  // Raise every request in mask together; grants are expected in index order.
  task automatic run_mask(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    int j;
    pend = mask;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        load(i);
        sb.push_back(model(i, tp[i], tr[i], ta[i]));
      end
    end
    req = req | mask;
    for (int n = 0; n < NREQ && pend != '0; n++) begin
      wait_ack(j);
      if (j < 0) begin
        req = '0;
        sb.delete();
        return;
      end
      req[j]  = 1'b0;
      pend[j] = 1'b0;
      if (ta[j] >= 0) begin
        repeat (ta[j]) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      wait_done();
    end
    req = '0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic set_one(input int i, input int p, input int r, input int a);
    tp[i] = p;
    tr[i] = r;
    ta[i] = a;
  endtask

  initial begin
    int j, a0, d0, nat;
    rst_n = 1'b0; req = '0; abort = 1'b0; period = '0; repeat_n = '0;
    for (int i = 0; i < NREQ; i++) set_one(i, 0, 0, -1);
    repeat (3) @(negedge clk);
    check("rst_buzzer", int'(buzzer), 1);
    check("rst_ack", int'(ack), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_owner", int'(owner), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 10-cycle note, three repeats.
    set_one(1, 10, 3, -1);
    run_mask(3'b010);

    // Simultaneous requests: 1 before 2.
    set_one(1, 7, 2, -1);
    set_one(2, 4, 3, -1);
    run_mask(3'b110);

    // Higher priority arriving mid-note waits for the current owner.
    set_one(2, 9, 2, -1);
    set_one(0, 5, 1, -1);
    load(2); load(0);
    sb.push_back(model(2, 9, 2, -1));
    sb.push_back(model(0, 5, 1, -1));
    req[2] = 1'b1;
    wait_ack(j);
    req[2] = 1'b0;
    repeat (5) @(negedge clk);
    req[0] = 1'b1;
    wait_ack(j);
    req = '0;
    wait_done();
    repeat (2) @(negedge clk);

    // Rest note: period 0, two repeats.
    set_one(0, 0, 2, -1);
    run_mask(3'b001);
    set_one(2, 1, 1, -1);
    run_mask(3'b100);

    // Abort seven samples into a note.
    set_one(1, 10, 3, 7);
    run_mask(3'b010);

    // Abort together with a request while idle blocks the grant.
    a0 = ack_count;
    req[1] = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    req   = '0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle_no_ack", ack_count - a0, 0);

    // Zero repeat count plays a single period.
    set_one(0, 8, 0, -1);
    run_mask(3'b001);

    // Reset mid-note: outputs to reset values, no done pulse.
    set_one(1, 10, 3, -1);
    load(1);
    sb.push_back(model(1, 10, 3, -1));
    req[1] = 1'b1;
    wait_ack(j);
    req = '0;
    repeat (8) @(negedge clk);
    d0 = done_count;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_buzzer", int'(buzzer), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_owner", int'(owner), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_done", done_count - d0, 0);
    check("midrst_idle", int'(busy), 0);

    // Randomized masks, periods, repeats and occasional aborts.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        tp[i] = $urandom_range(0, 20);
        tr[i] = $urandom_range(0, 4);
        nat   = model(i, tp[i], tr[i], -1).done_at;
        ta[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nat - 1) : -1;
      end
      run_mask(NREQ'($urandom_range(1, 7)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
